// File: rtl/bus_master_ctrl.sv
// Initiator for the 8-bit async register bus: turns one-cycle requests into SETUP/STROBE/HOLD/DONE
// bus cycles. Define BUS_WAIT_EN to add the active-low WAIT_ input that stretches the strobe phase.
module bus_master_ctrl #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       req_wr,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
`ifdef BUS_WAIT_EN
   input  logic       WAIT_,
`endif
   output logic       busy,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       CS_,
   output logic       OE_,
   output logic       WR_,
   output logic [7:0] Addr,
   inout  wire  [7:0] data_bus,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] L_STROBE = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(HOLD_CYC - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_accept;
   logic             w_capture;
   logic             w_wait_hold;
   logic             w_wr_eff;
   logic             w_on_bus;

   logic             r_wr;
   logic [7:0]       r_addr;
   logic [7:0]       r_wdata;
   logic [7:0]       r_rdata;
   logic             r_cs_n;
   logic             r_oe_n;
   logic             r_wr_n;
   logic             r_drv;
   logic             r_busy;
   logic             r_ack;

`ifdef BUS_WAIT_EN
   logic r_wait_s1;
   logic r_wait_s2;

   // Two-flop synchroniser; idles high so a reset never looks like a wait request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wait_s1 <= 1'b1;
         r_wait_s2 <= 1'b1;
      end else begin
         r_wait_s1 <= WAIT_;
         r_wait_s2 <= r_wait_s1;
      end
   end

   assign w_wait_hold = !r_wait_s2;
`else
   assign w_wait_hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = L_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_STROBE;
               w_cnt_nxt   = L_STROBE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_STROBE: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (!w_wait_hold) begin
               // Last strobe cycle: OE_ is still low here, so read data is stable.
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = L_HOLD;
               w_capture   = !r_wr;
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Pins are registered from the next state so they change on the same edge as the FSM.
   assign w_wr_eff = w_accept ? req_wr : r_wr;
   assign w_on_bus = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                     (w_state_nxt == S_HOLD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr    <= 1'b0;
         r_addr  <= 8'h00;
         r_wdata <= 8'h00;
         r_rdata <= 8'h00;
         r_cs_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_drv   <= 1'b0;
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_capture) begin
            r_rdata <= data_bus;
         end
         r_cs_n <= !w_on_bus;
         r_oe_n <= !((w_state_nxt == S_STROBE) && !w_wr_eff);
         r_wr_n <= !((w_state_nxt == S_STROBE) && w_wr_eff);
         r_drv  <= w_on_bus && w_wr_eff;
         r_busy <= (w_state_nxt != S_IDLE);
         r_ack  <= (w_state_nxt == S_DONE);
      end
   end

   assign data_bus    = r_drv ? r_wdata : 8'bzzzz_zzzz;
   assign busy        = r_busy;
   assign ack         = r_ack;
   assign rdata       = r_rdata;
   assign CS_         = r_cs_n;
   assign OE_         = r_oe_n;
   assign WR_         = r_wr_n;
   assign Addr        = r_addr;
   assign o_dbg_state = r_state;

endmodule
